// File: rtl/pwm_pkg.sv
// Shared widths and types for the motor-speed PWM generator.
package pwm_pkg;

  localparam int DUTY_W = 4;
  localparam logic [DUTY_W-1:0] CNT_MAX = 4'd15;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits a one-clock tick every PRESCALE clocks (constant 1 when PRESCALE=1).
module pwm_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] r_pre_cnt;

  assign tick = (r_pre_cnt == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pwm.sv
// Motor-speed PWM: 16-step period counter, duty latched at period wrap, registered compare output.
module pwm
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  duty_t ALU_result,
  output logic  speed_motor
);

  logic  w_tick;
  logic  w_wrap;
  duty_t r_cnt;
  duty_t r_duty_q;
  logic  r_speed;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  // Duty only changes at the wrap edge so no pulse is ever cut short.
  assign w_wrap = w_tick && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty_q <= '0;
      r_speed  <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_wrap) begin
        r_duty_q <= ALU_result;
      end
      r_speed <= (r_cnt < r_duty_q);
    end
  end

  assign speed_motor = r_speed;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: per-period scoreboard on a PRESCALE=1 instance plus scenario checks.
module tb_pwm;
  import pwm_pkg::*;

  logic  clk  = 1'b0;
  logic  rst  = 1'b1;
  logic  rst4 = 1'b1;
  duty_t alu  = 4'd0;
  duty_t alu4 = 4'd0;
  logic  sm;
  logic  sm4;

  int checks = 0;
  int errors = 0;

  int          edges = 0;
  duty_t       exp_q[$];
  logic [15:0] act_mask = '0;
  logic [15:0] exp_mask;
  duty_t       exp_n;
  int          pos;

  pwm #(.PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALU_result (alu),
    .speed_motor(sm)
  );

  pwm #(.PRESCALE(4)) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .ALU_result (alu4),
    .speed_motor(sm4)
  );

  always #5 clk = ~clk;

  // Scoreboard producer: the duty seen at each wrap edge governs the following period.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      edges = 0;
      exp_q.delete();
      exp_q.push_back(4'd0);
    end else begin
      edges = edges + 1;
      if (edges % 16 == 0) exp_q.push_back(alu);
    end
  end

  // Scoreboard consumer: collect 16 output samples per period and compare the pulse shape.
  initial forever begin
    @(negedge clk);
    if (!rst && edges > 0) begin
      pos = (edges - 1) % 16;
      if (pos == 0) act_mask = '0;
      act_mask[pos] = sm;
      if (pos == 15) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL period_queue empty actual_mask=%h", act_mask);
        end else begin
          exp_n    = exp_q.pop_front();
          exp_mask = 16'((32'h1 << exp_n) - 32'h1);
          if (act_mask !== exp_mask) begin
            errors++;
            $display("FAIL period_mask at t=%0t actual=%h required=%h", $time, act_mask, exp_mask);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic set_alu(input duty_t v);
    @(posedge clk);
    #2;
    alu = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu = 4'hF;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (sm !== 1'b0) begin errors++; $display("FAIL reset_hold actual=%b required=0", sm); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sm !== 1'b0) begin errors++; $display("FAIL release_first actual=%b required=0", sm); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (sm !== 1'b0) begin errors++; $display("FAIL release_low clk=%0d actual=%b required=0", i, sm); end
    end
    @(negedge clk);
    checks++;
    if (sm !== 1'b1) begin errors++; $display("FAIL release_first_high actual=%b required=1", sm); end
  endtask

  task automatic test_zero_half();
    int hi;
    set_alu(4'd0);
    repeat (32) @(posedge clk);
    hi = 0;
    repeat (224) begin
      @(negedge clk);
      if (sm) hi++;
    end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL zero_duty highs actual=%0d required=0", hi); end
    set_alu(4'd8);
    repeat (256) @(posedge clk);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      set_alu(duty_t'(v));
      repeat (255) @(posedge clk);
    end
  endtask

  task automatic test_mid_change();
    int hi_a;
    int hi_b;
    int budget;
    set_alu(4'd3);
    repeat (40) @(posedge clk);
    budget = 0;
    do begin
      @(posedge clk);
      budget++;
    end while (edges % 16 != 5 && budget < 32);
    checks++;
    if (edges % 16 != 5) begin errors++; $display("FAIL mid_align timeout edges=%0d required_phase=5", edges); end
    #2;
    alu = 4'd12;
    hi_a = 0;
    hi_b = 0;
    repeat (12) begin
      @(negedge clk);
      if (sm) hi_a++;
    end
    repeat (16) begin
      @(negedge clk);
      if (sm) hi_b++;
    end
    checks++;
    if (hi_a !== 0) begin errors++; $display("FAIL mid_rest_of_period highs actual=%0d required=0", hi_a); end
    checks++;
    if (hi_b !== 12) begin errors++; $display("FAIL mid_next_period highs actual=%0d required=12", hi_b); end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_async_reset();
    int budget;
    set_alu(4'd10);
    repeat (40) @(posedge clk);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (sm !== 1'b1 && budget < 64);
    checks++;
    if (sm !== 1'b1) begin errors++; $display("FAIL async_wait_high timeout actual=%b required=1", sm); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (sm !== 1'b0) begin errors++; $display("FAIL async_drop actual=%b required=0", sm); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sm !== 1'b0) begin errors++; $display("FAIL async_release_first actual=%b required=0", sm); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (sm !== 1'b0) begin errors++; $display("FAIL async_release_low clk=%0d actual=%b required=0", i, sm); end
    end
    @(negedge clk);
    checks++;
    if (sm !== 1'b1) begin errors++; $display("FAIL async_first_high actual=%b required=1", sm); end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_prescale();
    int hi;
    int mism;
    logic expv;
    alu4 = 4'd4;
    repeat (3) @(negedge clk);
    rst4 = 1'b0;
    hi = 0;
    mism = 0;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      expv = (k >= 65 && k <= 80);
      if (sm4) hi++;
      if (sm4 !== expv) mism++;
      if (k == 64) begin
        checks++;
        if (hi !== 0 || mism !== 0) begin
          errors++;
          $display("FAIL prescale_first_period highs=%0d mism=%0d required highs=0 mism=0", hi, mism);
        end
        hi = 0;
        mism = 0;
      end
    end
    checks++;
    if (hi !== 16 || mism !== 0) begin
      errors++;
      $display("FAIL prescale_second_period highs=%0d mism=%0d required highs=16 mism=0", hi, mism);
    end
  endtask

  initial begin
    test_reset();
    test_zero_half();
    test_sweep();
    test_mid_change();
    test_async_reset();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
